// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer for the 16-bit-instruction / 8-bit-data CPU.
// Fetch, decode, execute or memory access, with bounded memory waits and sticky halt/error states.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   input  logic        imem_ready,
   input  logic [15:0] instr,
   output logic        ir_en,
   input  logic        zero,
   output logic        pc_en,
   output logic        memtoreg,
   output logic        pcsrc,
   output logic        alusrc,
   output logic        regdst,
   output logic        regwrite,
   output logic        jump,
   output logic [2:0]  alucontrol,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ready,
   output logic        halted,
   output logic [1:0]  err_code
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

   localparam logic [2:0] OP_R    = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_LB   = 3'b010;
   localparam logic [2:0] OP_SB   = 3'b011;
   localparam logic [2:0] OP_BEQ  = 3'b100;
   localparam logic [2:0] OP_J    = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b111;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT, S_ILLEGAL, S_ERR
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    op_q, op_d;
   logic [2:0]    funct_q, funct_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    err_q, err_d;
   logic [2:0]    r_alu;

   // Only the opcode and funct fields matter to the control path.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{instr[12:6], instr[2:0]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         op_q    <= 3'b000;
         funct_q <= 3'b000;
         cnt_q   <= '0;
         err_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         funct_q <= funct_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      funct_d = funct_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ready) begin
               op_d    = instr[15:13];
               funct_d = instr[5:3];
               cnt_d   = '0;
               state_d = S_DECODE;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               err_d   = 2'b11;
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DECODE: begin
            case (op_q)
               OP_R, OP_ADDI, OP_BEQ, OP_J: state_d = S_EXEC;
               OP_LB, OP_SB:                state_d = S_MEM;
               OP_HALT: begin
                  err_d   = 2'b01;
                  state_d = S_HALT;
               end
               default: begin
                  err_d   = 2'b10;
                  state_d = S_ILLEGAL;
               end
            endcase
         end
         S_EXEC: begin
            cnt_d   = '0;
            state_d = S_FETCH;
         end
         // Ready is tested before the timeout so a coinciding ready still completes.
         S_MEM: begin
            if (dmem_ready) begin
               cnt_d   = '0;
               state_d = S_FETCH;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               err_d   = 2'b11;
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_HALT, S_ILLEGAL, S_ERR: state_d = state_q;
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      r_alu = ALU_ADD;
      case (funct_q)
         3'b010, 3'b110, 3'b000, 3'b001, 3'b111: r_alu = funct_q;
         default: r_alu = ALU_ADD;
      endcase
   end

   // Outputs are forced low while reset is held so nothing leaks during async reset.
   always_comb begin
      imem_req   = 1'b0;
      ir_en      = 1'b0;
      pc_en      = 1'b0;
      memtoreg   = 1'b0;
      pcsrc      = 1'b0;
      alusrc     = 1'b0;
      regdst     = 1'b0;
      regwrite   = 1'b0;
      jump       = 1'b0;
      alucontrol = 3'b000;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      halted     = 1'b0;
      err_code   = 2'b00;
      if (reset) begin
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_en    = imem_ready;
            end
            S_EXEC: begin
               pc_en = 1'b1;
               case (op_q)
                  OP_R: begin
                     regdst     = 1'b1;
                     regwrite   = 1'b1;
                     alucontrol = r_alu;
                  end
                  OP_ADDI: begin
                     alusrc     = 1'b1;
                     regwrite   = 1'b1;
                     alucontrol = ALU_ADD;
                  end
                  OP_BEQ: begin
                     alucontrol = ALU_SUB;
                     pcsrc      = zero;
                  end
                  OP_J:    jump = 1'b1;
                  default: jump = 1'b0;
               endcase
            end
            S_MEM: begin
               alusrc     = 1'b1;
               alucontrol = ALU_ADD;
               dmem_req   = 1'b1;
               dmem_we    = (op_q == OP_SB);
               if (dmem_ready) begin
                  pc_en = 1'b1;
                  if (op_q == OP_LB) begin
                     memtoreg = 1'b1;
                     regwrite = 1'b1;
                  end
               end
            end
            S_HALT, S_ILLEGAL, S_ERR: begin
               halted   = 1'b1;
               err_code = err_q;
            end
            default: halted = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected output words built from instruction-level
// rules (fetch wait, decode, execute/memory, terminal) and compared cycle by cycle.
module tb_multicycle_ctrl;

   localparam int MEM_TIMEOUT = 15;

   localparam int B_IMEM   = 16;
   localparam int B_IREN   = 15;
   localparam int B_PCEN   = 14;
   localparam int B_MTR    = 13;
   localparam int B_PCSRC  = 12;
   localparam int B_ALUSRC = 11;
   localparam int B_REGDST = 10;
   localparam int B_REGW   = 9;
   localparam int B_JUMP   = 8;
   localparam int B_DREQ   = 4;
   localparam int B_DWE    = 3;
   localparam int B_HALT   = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req, imem_ready, ir_en, zero, pc_en;
   logic [15:0] instr;
   logic        memtoreg, pcsrc, alusrc, regdst, regwrite, jump;
   logic [2:0]  alucontrol;
   logic        dmem_req, dmem_we, dmem_ready, halted;
   logic [1:0]  err_code;
   logic [16:0] obs_vec;

   int checks = 0;
   int errors = 0;

   logic [16:0] exp_q[$];
   logic [18:0] stim_q[$];

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_ready(imem_ready), .instr(instr),
      .ir_en(ir_en), .zero(zero), .pc_en(pc_en),
      .memtoreg(memtoreg), .pcsrc(pcsrc), .alusrc(alusrc), .regdst(regdst),
      .regwrite(regwrite), .jump(jump), .alucontrol(alucontrol),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .halted(halted), .err_code(err_code)
   );

   assign obs_vec = {imem_req, ir_en, pc_en, memtoreg, pcsrc, alusrc, regdst, regwrite,
                     jump, alucontrol, dmem_req, dmem_we, halted, err_code};

   // ---------------- drivers ----------------
   task automatic drive_cycle(input logic imr, input logic dmr, input logic z,
                              input logic [15:0] ins, output logic [16:0] got);
      imem_ready = imr;
      dmem_ready = dmr;
      zero       = z;
      instr      = ins;
      @(negedge clk);
      got = obs_vec;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      zero       = 1'b0;
      instr      = 16'h0000;
      exp_q.delete();
      stim_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // ---------------- reference model ----------------
   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic imr, input logic dmr, input logic z,
                       input logic [15:0] ins, input logic [16:0] e);
      stim_q.push_back({imr, dmr, z, ins});
      exp_q.push_back(e);
   endtask

   function automatic logic [2:0] alu_of(input logic [2:0] f);
      if (f inside {3'b010, 3'b110, 3'b000, 3'b001, 3'b111}) return f;
      return 3'b010;
   endfunction

   function automatic logic [16:0] mem_busy(input logic store);
      logic [16:0] e;
      e = '0;
      e[B_ALUSRC] = 1'b1;
      e[7:5]      = 3'b010;
      e[B_DREQ]   = 1'b1;
      e[B_DWE]    = store;
      return e;
   endfunction

   function automatic logic [16:0] term(input logic [1:0] code);
      logic [16:0] e;
      e = '0;
      e[B_HALT] = 1'b1;
      e[1:0]    = code;
      return e;
   endfunction

   // One instruction: fw idle fetch cycles, mw idle memory cycles, hold terminal cycles.
   task automatic model_instr(input logic [15:0] ins, input int fw, input int mw,
                              input logic z, input int hold);
      logic [2:0]  op;
      logic [16:0] e;
      op = ins[15:13];
      for (int i = 0; i < fw; i++) begin
         e = '0; e[B_IMEM] = 1'b1;
         push(1'b0, rbit(), z, ins, e);
      end
      e = '0; e[B_IMEM] = 1'b1; e[B_IREN] = 1'b1;
      push(1'b1, rbit(), z, ins, e);
      push(rbit(), rbit(), z, ins, '0);
      e = '0;
      case (op)
         3'b000: begin
            e[B_PCEN] = 1'b1; e[B_REGDST] = 1'b1; e[B_REGW] = 1'b1; e[7:5] = alu_of(ins[5:3]);
            push(rbit(), rbit(), z, ins, e);
         end
         3'b001: begin
            e[B_PCEN] = 1'b1; e[B_ALUSRC] = 1'b1; e[B_REGW] = 1'b1; e[7:5] = 3'b010;
            push(rbit(), rbit(), z, ins, e);
         end
         3'b100: begin
            e[B_PCEN] = 1'b1; e[7:5] = 3'b110; e[B_PCSRC] = z;
            push(rbit(), rbit(), z, ins, e);
         end
         3'b101: begin
            e[B_PCEN] = 1'b1; e[B_JUMP] = 1'b1;
            push(rbit(), rbit(), z, ins, e);
         end
         3'b010, 3'b011: begin
            for (int i = 0; i < mw; i++) push(rbit(), 1'b0, z, ins, mem_busy(op[0]));
            e = mem_busy(op[0]);
            e[B_PCEN] = 1'b1;
            if (op == 3'b010) begin
               e[B_MTR] = 1'b1; e[B_REGW] = 1'b1;
            end
            push(rbit(), 1'b1, z, ins, e);
         end
         3'b111: for (int i = 0; i < hold; i++) push(rbit(), rbit(), z, ins, term(2'b01));
         default: for (int i = 0; i < hold; i++) push(rbit(), rbit(), z, ins, term(2'b10));
      endcase
   endtask

   task automatic model_fetch_timeout(input int hold);
      logic [16:0] e;
      e = '0; e[B_IMEM] = 1'b1;
      for (int i = 0; i < MEM_TIMEOUT; i++) push(1'b0, rbit(), 1'b0, 16'h0000, e);
      for (int i = 0; i < hold; i++) push(rbit(), rbit(), 1'b0, 16'h0000, term(2'b11));
   endtask

   task automatic model_mem_timeout(input logic [15:0] ins, input int hold);
      logic [16:0] e;
      e = '0; e[B_IMEM] = 1'b1; e[B_IREN] = 1'b1;
      push(1'b1, 1'b0, 1'b0, ins, e);
      push(rbit(), 1'b0, 1'b0, ins, '0);
      for (int i = 0; i < MEM_TIMEOUT; i++) push(rbit(), 1'b0, 1'b0, ins, mem_busy(ins[13]));
      for (int i = 0; i < hold; i++) push(rbit(), rbit(), 1'b0, ins, term(2'b11));
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [16:0] got;
      reset = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b1; instr = 16'h0010;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         got = obs_vec;
         checks++;
         if (got !== 17'h0) begin
            errors++; $display("FAIL reset_outputs got %h exp %h", got, 17'h0);
         end
      end
      do_reset();
   endtask

   task automatic test_r_first();
      logic [16:0] got, e;
      logic [18:0] s;
      int cyc = 0;
      do_reset();
      model_instr(16'h0010, 0, 0, 1'b0, 0);
      e = '0; e[B_IMEM] = 1'b1;
      push(1'b0, 1'b0, 1'b0, 16'h0000, e);
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         drive_cycle(s[18], s[17], s[16], s[15:0], got);
         checks++;
         if (got !== e) begin
            errors++; $display("FAIL r_first cyc %0d got %h exp %h", cyc, got, e);
         end
         cyc++;
      end
   endtask

   task automatic test_beq();
      logic [16:0] got, e;
      logic [18:0] s;
      int cyc = 0;
      do_reset();
      model_instr(16'h8005, 0, 0, 1'b1, 0);
      model_instr(16'h8005, 2, 0, 1'b0, 0);
      model_instr(16'hA000, 1, 0, 1'b1, 0);
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         drive_cycle(s[18], s[17], s[16], s[15:0], got);
         checks++;
         if (got !== e) begin
            errors++; $display("FAIL beq_jump cyc %0d got %h exp %h", cyc, got, e);
         end
         cyc++;
      end
   endtask

   task automatic test_mem_wait();
      logic [16:0] got, e;
      logic [18:0] s;
      int cyc = 0;
      do_reset();
      model_instr(16'h4003, 0, 3, 1'b0, 0);
      model_instr(16'h6003, 0, 0, 1'b0, 0);
      model_instr(16'h4003, 0, MEM_TIMEOUT - 1, 1'b0, 0);
      model_instr(16'h2001, MEM_TIMEOUT - 1, 0, 1'b0, 0);
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         drive_cycle(s[18], s[17], s[16], s[15:0], got);
         checks++;
         if (got !== e) begin
            errors++; $display("FAIL mem_wait cyc %0d got %h exp %h", cyc, got, e);
         end
         cyc++;
      end
   endtask

   task automatic test_back_to_back();
      logic [16:0] got, e;
      logic [18:0] s;
      logic [15:0] ins;
      logic [2:0]  ops [6];
      int cyc = 0;
      ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
      do_reset();
      for (int n = 0; n < 60; n++) begin
         ins = 16'($urandom_range(0, 16'hFFFF));
         ins[15:13] = ops[$urandom_range(0, 5)];
         model_instr(ins, $urandom_range(0, 4), $urandom_range(0, MEM_TIMEOUT - 1), rbit(), 0);
      end
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         drive_cycle(s[18], s[17], s[16], s[15:0], got);
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL back_to_back cyc %0d instr %h got %h exp %h", cyc, s[15:0], got, e);
         end
         cyc++;
      end
   endtask

   task automatic test_timeouts();
      logic [16:0] got, e;
      logic [18:0] s;
      int cyc = 0;
      do_reset();
      model_mem_timeout(16'h6003, 6);
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         drive_cycle(s[18], s[17], s[16], s[15:0], got);
         checks++;
         if (got !== e) begin
            errors++; $display("FAIL sb_timeout cyc %0d got %h exp %h", cyc, got, e);
         end
         cyc++;
      end
      cyc = 0;
      do_reset();
      model_fetch_timeout(4);
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         drive_cycle(s[18], s[17], s[16], s[15:0], got);
         checks++;
         if (got !== e) begin
            errors++; $display("FAIL fetch_timeout cyc %0d got %h exp %h", cyc, got, e);
         end
         cyc++;
      end
   endtask

   task automatic test_terminal_ops();
      logic [16:0] got, e;
      logic [18:0] s;
      logic [15:0] words [2];
      words = '{16'hC000, 16'hE000};
      for (int w = 0; w < 2; w++) begin
         int cyc = 0;
         do_reset();
         model_instr(words[w], 1, 0, 1'b0, 5);
         while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            drive_cycle(s[18], s[17], s[16], s[15:0], got);
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL terminal_op %h cyc %0d got %h exp %h", words[w], cyc, got, e);
            end
            cyc++;
         end
      end
   endtask

   task automatic test_reset_mid_mem();
      logic [16:0] got, e;
      do_reset();
      drive_cycle(1'b1, 1'b0, 1'b0, 16'h4003, got);
      drive_cycle(1'b0, 1'b0, 1'b0, 16'h4003, got);
      imem_ready = 1'b0; dmem_ready = 1'b0;
      @(negedge clk);
      e = mem_busy(1'b0);
      checks++;
      if (obs_vec !== e) begin
         errors++; $display("FAIL mid_mem_busy got %h exp %h", obs_vec, e);
      end
      #2 reset = 1'b0;
      dmem_ready = 1'b1;
      #1;
      checks++;
      if (obs_vec !== 17'h0) begin
         errors++; $display("FAIL mid_mem_async_reset got %h exp %h", obs_vec, 17'h0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (obs_vec !== 17'h0) begin
         errors++; $display("FAIL mid_mem_reset_held got %h exp %h", obs_vec, 17'h0);
      end
      reset = 1'b1;
      dmem_ready = 1'b0;
      drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000, got);
      e = '0; e[B_IMEM] = 1'b1;
      checks++;
      if (got !== e) begin
         errors++; $display("FAIL post_reset_fetch got %h exp %h", got, e);
      end
   endtask

   initial begin
      test_reset();
      test_r_first();
      test_beq();
      test_mem_wait();
      test_back_to_back();
      test_timeouts();
      test_terminal_ops();
      test_reset_mid_mem();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
